data_mem_align: RTL and testbench
=================================

// Module: data_mem_align
// PURPOSE
// Sits between the memory stage and the 64-bit synchronous data SRAM. Turns byte-addressed
// load/store requests of 1/2/4/8 bytes into word-addressed SRAM beats with byte strobes.
// Splits any access crossing an 8-byte boundary into two beats and reassembles read data.
// Returns right-justified read data, which the memory stage then sign/zero-extends.
// PARAMETERS
// MEM_BYTES  524288  data memory size in bytes; power of two, multiple of 8
// WADDR_W    16      SRAM word-address width, = log2(MEM_BYTES/8)
// PORTS
// clk              in   1   clock
// reset            in   1   asynchronous, active-high reset
// data_req_i       in   1   request valid; accepted when req_ready_o=1
// data_addr_i      in   64  byte address
// data_byte_en_i   in   2   size: 00=BYTE 01=HALF_WORD 10=WORD 11=DOUBLE_WORD
// data_wr_i        in   1   1=store, 0=load
// data_wr_data_i   in   64  store data, right-justified
// req_ready_o      out  1   can accept a request this cycle
// rsp_valid_o      out  1   one-cycle pulse: load data / store completion
// rsp_err_o        out  1   qualifies rsp_valid_o: access out of range
// mem_rd_data_o    out  64  load data, right-justified, unused upper bytes 0
// sram_req_o       out  1   SRAM beat enable
// sram_we_o        out  1   SRAM write enable
// sram_addr_o      out  WADDR_W  SRAM word address
// sram_strb_o      out  8   SRAM byte-write strobes
// sram_wdata_o     out  64  SRAM write data, lane-aligned
// sram_rdata_i     in   64  SRAM read data, valid the cycle after a read beat
// BEHAVIOUR
// - Definitions: off=addr[2:0], n=1<<byte_en, cross=(off+n>8), oor=(addr+n>MEM_BYTES),
//   using 65-bit addr+n so there is no wrap.
// - FSM states: IDLE, BEAT2, RESP. Reset enters IDLE and clears all registers.
// - req_ready_o=1 in IDLE and RESP; 0 in BEAT2 and while reset is high.
// - Accept (req & ready): beat0 is issued combinationally in the same cycle.
//   - sram_addr=addr[WADDR_W+2:3].
//   - Request fields and off are latched.
//   - Next state: BEAT2 if cross & !oor, else RESP.
// - oor at accept: no SRAM beat (sram_req_o=0); next state RESP with rsp_err_o=1 and data 0.
// - BEAT2: issues beat1 at word addr+1 with the latched fields. Captures sram_rdata_i
//   (beat0 data) into lo_q. Next state RESP. No new request is accepted.
// - RESP: rsp_valid_o=1.
//   - Not cross: mem_rd_data_o = (sram_rdata_i >> 8*off) masked to n bytes.
//   - cross: mem_rd_data_o = ({sram_rdata_i,lo_q} >> 8*off)[63:0], masked to n bytes.
//   - Stores: mem_rd_data_o=0.
//   - Same cycle: a new request may be accepted (back-to-back); else next state IDLE.
// - Store lanes: W128={64'b0,wdata}<<8*off; M16=((1<<n)-1)<<off.
//   - beat0: strb=M16[7:0], wdata=W128[63:0]. beat1: strb=M16[15:8], wdata=W128[127:64].
//   - Load beats have strb=0 and we=0.
// - Throughput: aligned accesses take 1 request per cycle, data 1 cycle after accept.
//   Crossing accesses occupy 2 beats, with data 2 cycles after accept.
// - All sram_* outputs are 0 unless a beat is issued, and are forced 0 while reset is high.
//   Reset values of all other outputs are 0, except req_ready_o, which is 1 after
//   reset deasserts.
// - Reset asserted mid-access (BEAT2/RESP) aborts it: no rsp_valid_o pulse, no further beats.
// - Inputs are sampled only on accept; changes while ready=0 are ignored.
// TESTING
// - Aligned DW load addr 0x10, SRAM word 2=0x1122334455667788 -> sram_addr=2 at accept;
//   next cycle rsp_valid, data 0x1122334455667788.
// - Byte store addr 0x13, wdata 0xAB -> one beat: addr=2, strb=0x08,
//   wdata[31:24]=0xAB; rsp_valid next cycle, err=0.
// - Crossing WORD load addr 0x0E:
//   - SRAM word1=0xDDCC_0000_0000_0000, word2=0x0000_0000_0000_BBAA.
//   - Beats at addr 1 then 2; rsp_valid 2 cycles after accept; data 0x0000_0000_BBAA_DDCC.
// - Crossing DW store addr 0x0B, wdata 0x0807060504030201:
//   - beat0: addr 1, strb 0xF8, wdata 0x0504030201000000.
//   - beat1: addr 2, strb 0x07, wdata 0x0000000000080706.
//   - ready low for 1 cycle.
// - Out of range: HALF_WORD load addr 0x7FFFF -> no sram_req; next cycle rsp_valid=1,
//   err=1, data 0.
// - Back-to-back plus reset: 3 aligned loads on consecutive cycles -> 3 consecutive rsp_valid.
//   Reset asserted in BEAT2 -> no rsp_valid, ready=1 after release.

Source files
------------

// File: rtl/data_mem_align_if.sv
// Bus bundle between the memory stage, data_mem_align and the 64-bit data SRAM.
// The slave modport is the aligner's view; master is the surrounding environment.
interface data_mem_align_if #(
    parameter int WADDR_W = 16
);
    logic               data_req_i;
    logic [63:0]        data_addr_i;
    logic [1:0]         data_byte_en_i;
    logic               data_wr_i;
    logic [63:0]        data_wr_data_i;
    logic               req_ready_o;
    logic               rsp_valid_o;
    logic               rsp_err_o;
    logic [63:0]        mem_rd_data_o;
    logic               sram_req_o;
    logic               sram_we_o;
    logic [WADDR_W-1:0] sram_addr_o;
    logic [7:0]         sram_strb_o;
    logic [63:0]        sram_wdata_o;
    logic [63:0]        sram_rdata_i;

    modport slave (
        input  data_req_i, data_addr_i, data_byte_en_i, data_wr_i, data_wr_data_i,
        input  sram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, mem_rd_data_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_strb_o, sram_wdata_o
    );

    modport master (
        output data_req_i, data_addr_i, data_byte_en_i, data_wr_i, data_wr_data_i,
        output sram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, mem_rd_data_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_strb_o, sram_wdata_o
    );
endinterface

// File: rtl/data_mem_align.sv
// Byte-addressed load/store to 64-bit word SRAM aligner: issues lane-aligned beats with
// strobes, splits 8-byte-boundary crossings into two beats and reassembles read data.
module data_mem_align #(
    parameter int MEM_BYTES = 524288,
    parameter int WADDR_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_align_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT2, RESP} state_t;

    state_t             state;
    logic [2:0]         off_q;
    logic [1:0]         size_q;
    logic               wr_q;
    logic               cross_q;
    logic               err_q;
    logic [WADDR_W-1:0] next_waddr_q;
    logic [7:0]         hi_strb_q;
    logic [63:0]        hi_wdata_q;
    logic [63:0]        lo_q;

    logic [2:0]   req_off;
    logic [3:0]   req_n;
    logic         req_cross;
    logic [64:0]  req_end;
    logic         req_oor;
    logic [127:0] req_w128;
    logic [15:0]  req_m16;
    logic         ready;
    logic         accept;

    assign req_off   = bus.data_addr_i[2:0];
    assign req_n     = 4'd1 << bus.data_byte_en_i;
    assign req_cross = ({1'b0, req_off} + req_n) > 4'd8;
    // 65-bit end address so a request near 2^64 cannot wrap back into range.
    assign req_end   = {1'b0, bus.data_addr_i} + {61'd0, req_n};
    assign req_oor   = req_end > 65'(MEM_BYTES);
    assign req_w128  = {64'd0, bus.data_wr_data_i} << {req_off, 3'b000};
    assign req_m16   = ((16'd1 << req_n) - 16'd1) << req_off;

    assign ready  = !reset && (state != BEAT2);
    assign accept = bus.data_req_i && ready;

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = (state == RESP);
    assign bus.rsp_err_o   = (state == RESP) && err_q;

    // Beat0 goes out combinationally on accept; beat1 replays the latched upper half.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        bus.sram_req_o   = 1'b0;
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_strb_o  = '0;
        bus.sram_wdata_o = '0;
        if (accept && !req_oor) begin
            bus.sram_req_o  = 1'b1;
            bus.sram_we_o   = bus.data_wr_i;
            bus.sram_addr_o = bus.data_addr_i[WADDR_W+2:3];
            if (bus.data_wr_i) begin
                bus.sram_strb_o  = req_m16[7:0];
                bus.sram_wdata_o = req_w128[63:0];
            end
        end else if (state == BEAT2) begin
            bus.sram_req_o   = 1'b1;
            bus.sram_we_o    = wr_q;
            bus.sram_addr_o  = next_waddr_q;
            bus.sram_strb_o  = hi_strb_q;
            bus.sram_wdata_o = hi_wdata_q;
        end
    end

    logic [127:0] rd_cat;
    logic [63:0]  rd_shift;
    logic [63:0]  rd_mask;

    always_comb begin
        rd_cat   = cross_q ? {bus.sram_rdata_i, lo_q} : {64'd0, bus.sram_rdata_i};
        rd_shift = 64'(rd_cat >> {off_q, 3'b000});
        case (size_q)
            2'b00:   rd_mask = 64'h0000_0000_0000_00FF;
            2'b01:   rd_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   rd_mask = 64'h0000_0000_FFFF_FFFF;
            default: rd_mask = '1;
        endcase
        bus.mem_rd_data_o = '0;
        if (state == RESP && !err_q && !wr_q) begin
            bus.mem_rd_data_o = rd_shift & rd_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            off_q        <= '0;
            size_q       <= '0;
            wr_q         <= 1'b0;
            cross_q      <= 1'b0;
            err_q        <= 1'b0;
            next_waddr_q <= '0;
            hi_strb_q    <= '0;
            hi_wdata_q   <= '0;
            lo_q         <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            case (state)
                BEAT2: begin
                    lo_q  <= bus.sram_rdata_i;
                    state <= RESP;
                end
                default: begin
                    if (accept) begin
                        off_q        <= req_off;
                        size_q       <= bus.data_byte_en_i;
                        wr_q         <= bus.data_wr_i;
                        cross_q      <= req_cross && !req_oor;
                        err_q        <= req_oor;
                        next_waddr_q <= bus.data_addr_i[WADDR_W+2:3] + 1'b1;
                        hi_strb_q    <= bus.data_wr_i ? req_m16[15:8] : 8'd0;
                        hi_wdata_q   <= bus.data_wr_i ? req_w128[127:64] : 64'd0;
                        state        <= (req_cross && !req_oor) ? BEAT2 : RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_align.sv
// Bench for data_mem_align: byte-level reference memory plus per-cycle scoreboard,
// directed literal cases, then randomized traffic.
module tb_data_mem_align;
    localparam int MEM_BYTES = 524288;
    localparam int WADDR_W   = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_align_if #(.WADDR_W(WADDR_W)) bus ();

    data_mem_align #(.MEM_BYTES(MEM_BYTES), .WADDR_W(WADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_word(input longint w);
        logic [31:0] a;
        a = 32'(w);
        return {(a * 32'h9E37_79B9) ^ 32'h5BD1_E995, (a ^ 32'hA5A5_0F0F) * 32'h85EB_CA6B};
    endfunction

    // SRAM model: beats sampled mid-cycle, applied at the following edge.
    logic [63:0] sram_mem [longint];

    function automatic logic [63:0] sram_word(input longint w);
        if (sram_mem.exists(w)) return sram_mem[w];
        return init_word(w);
    endfunction

    bit          pend_v = 1'b0;
    bit          pend_we;
    longint      pend_a;
    logic [7:0]  pend_strb;
    logic [63:0] pend_wd;

    always @(negedge clk) begin
        pend_v    = bus.sram_req_o;
        pend_we   = bus.sram_we_o;
        pend_a    = longint'(bus.sram_addr_o);
        pend_strb = bus.sram_strb_o;
        pend_wd   = bus.sram_wdata_o;
    end

    always @(posedge clk) begin : sram_p
        logic [63:0] word;
        if (pend_v) begin
            if (pend_we) begin
                word = sram_word(pend_a);
                for (int l = 0; l < 8; l++)
                    if (pend_strb[l]) word[8*l +: 8] = pend_wd[8*l +: 8];
                sram_mem[pend_a] = word;
            end else begin
                bus.sram_rdata_i <= sram_word(pend_a);
            end
        end
    end

    // Reference: flat byte memory, with the SRAM's initial contents as background.
    logic [7:0] ref_bytes [longint];

    function automatic logic [7:0] ref_byte(input longint b);
        logic [63:0] w;
        if (ref_bytes.exists(b)) return ref_bytes[b];
        w = init_word(b >>> 3);
        return w[8*int'(b & 7) +: 8];
    endfunction

    task automatic preset_word(input longint w, input logic [63:0] v);
        sram_mem[w] = v;
        for (int l = 0; l < 8; l++) ref_bytes[w*8 + l] = v[8*l +: 8];
    endtask

    typedef struct packed {
        logic               we;
        logic [WADDR_W-1:0] addr;
        logic [7:0]         strb;
        logic [63:0]        wdata;
    } beat_t;

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } rsp_t;

    beat_t exp_beat [int];
    rsp_t  exp_rsp  [int];
    bit    busy     [int];
    int    cyc = 0;

    // Schedules beats and response of a request accepted in cycle t, byte by byte.
    task automatic model_accept(input int t, input logic [63:0] addr, input logic [1:0] size,
                                input logic wr, input logic [63:0] wd);
        int          n;
        int          nb;
        int          k;
        int          lane;
        logic [64:0] endp;
        longint      base;
        longint      w0;
        longint      b;
        beat_t       bt [2];
        logic [63:0] ld;
        n    = 1 << size;
        endp = {1'b0, addr} + 65'(n);
        if (endp > 65'(MEM_BYTES)) begin
            exp_rsp[t+1] = '{err: 1'b1, data: 64'd0};
            return;
        end
        base = longint'(addr);
        w0   = base >>> 3;
        nb   = (((base + n - 1) >>> 3) != w0) ? 2 : 1;
        ld   = '0;
        for (int j = 0; j < 2; j++)
            bt[j] = '{we: wr, addr: WADDR_W'(w0 + j), strb: 8'd0, wdata: 64'd0};
        for (int i = 0; i < n; i++) begin
            b    = base + i;
            k    = ((b >>> 3) != w0) ? 1 : 0;
            lane = int'(b & 7);
            if (wr) begin
                bt[k].strb[lane]          = 1'b1;
                bt[k].wdata[8*lane +: 8]  = wd[8*i +: 8];
                ref_bytes[b]              = wd[8*i +: 8];
            end else begin
                ld[8*i +: 8] = ref_byte(b);
            end
        end
        for (int j = 0; j < nb; j++) exp_beat[t+j] = bt[j];
        if (nb == 2) busy[t+1] = 1'b1;
        exp_rsp[t+nb] = '{err: 1'b0, data: wr ? 64'd0 : ld};
    endtask

    function automatic logic [63:0] strb_mask(input logic [7:0] s);
        logic [63:0] m;
        for (int l = 0; l < 8; l++) m[8*l +: 8] = {8{s[l]}};
        return m;
    endfunction

    always @(negedge clk) begin : compare_p
        beat_t eb;
        rsp_t  er;
        bit    exp_ready;
        if (reset) begin
            check("rst_ready", 64'(bus.req_ready_o), 64'd0);
            check("rst_sram_req", 64'(bus.sram_req_o), 64'd0);
            check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
            exp_beat.delete();
            exp_rsp.delete();
            busy.delete();
        end else begin
            exp_ready = !busy.exists(cyc);
            check("ready", 64'(bus.req_ready_o), 64'(exp_ready));
            if (bus.data_req_i && exp_ready)
                model_accept(cyc, bus.data_addr_i, bus.data_byte_en_i, bus.data_wr_i,
                             bus.data_wr_data_i);
            if (exp_beat.exists(cyc)) begin
                eb = exp_beat[cyc];
                check("sram_req", 64'(bus.sram_req_o), 64'd1);
                check("sram_we", 64'(bus.sram_we_o), 64'(eb.we));
                check("sram_addr", 64'(bus.sram_addr_o), 64'(eb.addr));
                check("sram_strb", 64'(bus.sram_strb_o), 64'(eb.strb));
                if (eb.we)
                    check("sram_wdata", bus.sram_wdata_o & strb_mask(eb.strb), eb.wdata);
                exp_beat.delete(cyc);
            end else begin
                check("sram_req_idle", 64'(bus.sram_req_o), 64'd0);
            end
            if (exp_rsp.exists(cyc)) begin
                er = exp_rsp[cyc];
                check("rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
                check("rsp_err", 64'(bus.rsp_err_o), 64'(er.err));
                check("rsp_data", bus.mem_rd_data_o, er.data);
                exp_rsp.delete(cyc);
            end else begin
                check("rsp_valid_idle", 64'(bus.rsp_valid_o), 64'd0);
            end
            if (busy.exists(cyc)) busy.delete(cyc);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [1:0] s, input logic w,
                         input logic [63:0] d);
        bus.data_req_i     = 1'b1;
        bus.data_addr_i    = a;
        bus.data_byte_en_i = s;
        bus.data_wr_i      = w;
        bus.data_wr_data_i = d;
    endtask

    // Idle cycles carry junk on the request fields; it must be ignored.
    task automatic idle();
        bus.data_req_i     = 1'b0;
        bus.data_addr_i    = {$urandom, $urandom};
        bus.data_byte_en_i = 2'($urandom);
        bus.data_wr_i      = 1'($urandom);
        bus.data_wr_data_i = {$urandom, $urandom};
    endtask

    task automatic issue(input logic [63:0] a, input logic [1:0] s, input logic w,
                         input logic [63:0] d);
        int waited;
        waited = 0;
        drive(a, s, w, d);
        while (!bus.req_ready_o && waited < 8) begin
            step();
            waited++;
        end
        if (waited >= 8) check("ready_wait_bound", 64'(waited), 64'd0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int          r;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lit_rst_ready", 64'(bus.req_ready_o), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("lit_ready_after_rst", 64'(bus.req_ready_o), 64'd1);
        check("lit_rsp_after_rst", 64'(bus.rsp_valid_o), 64'd0);
        check("lit_sram_after_rst", 64'(bus.sram_req_o), 64'd0);
        step();

        // Aligned DW load
        preset_word(2, 64'h1122_3344_5566_7788);
        drive(64'h10, 2'b11, 1'b0, 64'd0);
        @(negedge clk);
        check("lit_dw_ld_req", 64'(bus.sram_req_o), 64'd1);
        check("lit_dw_ld_addr", 64'(bus.sram_addr_o), 64'd2);
        step(); idle();
        @(negedge clk);
        check("lit_dw_ld_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("lit_dw_ld_data", bus.mem_rd_data_o, 64'h1122_3344_5566_7788);
        step();

        // Byte store
        drive(64'h13, 2'b00, 1'b1, 64'hAB);
        @(negedge clk);
        check("lit_b_st_we", 64'(bus.sram_we_o), 64'd1);
        check("lit_b_st_addr", 64'(bus.sram_addr_o), 64'd2);
        check("lit_b_st_strb", 64'(bus.sram_strb_o), 64'h08);
        check("lit_b_st_wdata", bus.sram_wdata_o, 64'h0000_0000_AB00_0000);
        step(); idle();
        @(negedge clk);
        check("lit_b_st_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("lit_b_st_err", 64'(bus.rsp_err_o), 64'd0);
        step();

        // Crossing WORD load
        preset_word(1, 64'hDDCC_0000_0000_0000);
        preset_word(2, 64'h0000_0000_0000_BBAA);
        drive(64'h0E, 2'b10, 1'b0, 64'd0);
        @(negedge clk);
        check("lit_x_ld_addr0", 64'(bus.sram_addr_o), 64'd1);
        step(); idle();
        @(negedge clk);
        check("lit_x_ld_ready", 64'(bus.req_ready_o), 64'd0);
        check("lit_x_ld_addr1", 64'(bus.sram_addr_o), 64'd2);
        check("lit_x_ld_early", 64'(bus.rsp_valid_o), 64'd0);
        step();
        @(negedge clk);
        check("lit_x_ld_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("lit_x_ld_data", bus.mem_rd_data_o, 64'h0000_0000_BBAA_DDCC);
        step();

        // Crossing DW store
        drive(64'h0B, 2'b11, 1'b1, 64'h0807_0605_0403_0201);
        @(negedge clk);
        check("lit_x_st_addr0", 64'(bus.sram_addr_o), 64'd1);
        check("lit_x_st_strb0", 64'(bus.sram_strb_o), 64'hF8);
        check("lit_x_st_wdata0", bus.sram_wdata_o, 64'h0504_0302_0100_0000);
        step(); idle();
        @(negedge clk);
        check("lit_x_st_ready", 64'(bus.req_ready_o), 64'd0);
        check("lit_x_st_addr1", 64'(bus.sram_addr_o), 64'd2);
        check("lit_x_st_strb1", 64'(bus.sram_strb_o), 64'h07);
        check("lit_x_st_wdata1", bus.sram_wdata_o, 64'h0000_0000_0008_0706);
        step();
        @(negedge clk);
        check("lit_x_st_valid", 64'(bus.rsp_valid_o), 64'd1);
        step();

        // Out of range
        drive(64'h7FFFF, 2'b01, 1'b0, 64'd0);
        @(negedge clk);
        check("lit_oor_no_beat", 64'(bus.sram_req_o), 64'd0);
        step(); idle();
        @(negedge clk);
        check("lit_oor_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("lit_oor_err", 64'(bus.rsp_err_o), 64'd1);
        check("lit_oor_data", bus.mem_rd_data_o, 64'd0);
        step();

        // Three back-to-back aligned loads
        drive(64'h100, 2'b11, 1'b0, 64'd0);
        step();
        drive(64'h108, 2'b11, 1'b0, 64'd0);
        @(negedge clk);
        check("lit_b2b_rsp0", 64'(bus.rsp_valid_o), 64'd1);
        step();
        drive(64'h110, 2'b11, 1'b0, 64'd0);
        @(negedge clk);
        check("lit_b2b_rsp1", 64'(bus.rsp_valid_o), 64'd1);
        step(); idle();
        @(negedge clk);
        check("lit_b2b_rsp2", 64'(bus.rsp_valid_o), 64'd1);
        step();
        @(negedge clk);
        check("lit_b2b_done", 64'(bus.rsp_valid_o), 64'd0);
        step();

        // Reset while in BEAT2 aborts the access
        drive(64'h2D, 2'b10, 1'b0, 64'd0);
        @(negedge clk);
        check("lit_abort_beat0", 64'(bus.sram_req_o), 64'd1);
        step(); idle();
        reset = 1'b1;
        @(negedge clk);
        check("lit_abort_no_beat1", 64'(bus.sram_req_o), 64'd0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("lit_abort_ready", 64'(bus.req_ready_o), 64'd1);
        check("lit_abort_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
        step();
        @(negedge clk);
        check("lit_abort_no_rsp2", 64'(bus.rsp_valid_o), 64'd0);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) step();
            end
            r = int'($urandom_range(0, 99));
            if (r < 80)      a = 64'($urandom_range(0, 4095));
            else if (r < 95) a = 64'(MEM_BYTES - 16) + 64'($urandom_range(0, 31));
            else             a = {$urandom, $urandom};
            issue(a, 2'($urandom), 1'($urandom), {$urandom, $urandom});
        end
        idle();
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
